// File: rtl/digitallock_pkg.sv
// Shared types and constants for the DigitalLock system-ID checker and future Avalon masters.
package digitallock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_ID  = 3'd1,
    ST_RD_TS  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4
  } sysid_state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_DEFAULT_ID = 32'd0;
  localparam logic [31:0] SYSID_DEFAULT_TS = 32'd1768956207;

  localparam int unsigned SYSID_RETRY_W = 4;

endpackage

// File: rtl/digitallock_wait_timer.sv
// Loadable saturating wait counter; expire is high once the count has reached MAX_COUNT.
module digitallock_wait_timer #(
  parameter int unsigned MAX_COUNT = 255,
  parameter int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             inc,
  output logic             expire
);

  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX_COUNT);

  logic [CNT_W-1:0] count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v >= MAX_VAL) return MAX_VAL;
    return v + 1'b1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

  assign expire = (count >= MAX_VAL);

endmodule

// File: rtl/digitallock_sysid_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp words and
// reports whether the loaded image matches the hardware.
module digitallock_sysid_checker
  import digitallock_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
  parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRY      = 2,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SYSID_RETRY_W-1:0] RETRY_LIMIT = SYSID_RETRY_W'(MAX_RETRY);

  sysid_state_e state, state_nxt;

  logic                     auto_pend;
  logic [SYSID_RETRY_W-1:0] retry_cnt;
  logic                     wait_expire;
  logic                     clr_flags;
  logic                     cap_id;
  logic                     cap_ts;
  logic                     do_check;
  logic                     set_timeout;
  logic                     retry_inc;
  logic                     retry_clr;

  // Stall counter restarts whenever the strobe is low or a word is accepted,
  // so each access (and each retry) gets its own full timeout window.
  digitallock_wait_timer #(
    .MAX_COUNT (TIMEOUT_CYCLES),
    .CNT_W     (WAIT_W)
  ) u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .load     (!avm_read || !avm_waitrequest),
    .load_val ('0),
    .inc      (avm_read && avm_waitrequest),
    .expire   (wait_expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      auto_pend <= AUTO_START;
    end else begin
      state     <= state_nxt;
      auto_pend <= 1'b0;
    end
  end

  always_comb begin
    state_nxt   = state;
    avm_read    = 1'b0;
    avm_address = SYSID_ADDR_ID;
    clr_flags   = 1'b0;
    cap_id      = 1'b0;
    cap_ts      = 1'b0;
    do_check    = 1'b0;
    set_timeout = 1'b0;
    retry_inc   = 1'b0;
    retry_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start || auto_pend) begin
          state_nxt = ST_RD_ID;
          clr_flags = 1'b1;
        end
      end
      ST_RD_ID, ST_RD_TS: begin
        avm_address = (state == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
        if (wait_expire) begin
          // Abort cycle: strobe is withdrawn for exactly one cycle.
          if (retry_cnt < RETRY_LIMIT) begin
            retry_inc = 1'b1;
            state_nxt = ST_RD_ID;
          end else begin
            set_timeout = 1'b1;
            state_nxt   = ST_FINISH;
          end
        end else begin
          avm_read = 1'b1;
          if (!avm_waitrequest) begin
            if (state == ST_RD_ID) begin
              cap_id    = 1'b1;
              state_nxt = ST_RD_TS;
            end else begin
              cap_ts    = 1'b1;
              state_nxt = ST_CHECK;
            end
          end
        end
      end
      ST_CHECK: begin
        do_check  = 1'b1;
        state_nxt = ST_FINISH;
      end
      ST_FINISH: begin
        retry_clr = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retry_cnt <= '0;
    end else if (retry_clr) begin
      retry_cnt <= '0;
    end else if (retry_inc) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end

  // Result flags and captured words; all cleared by reset so software sees a clean slate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      if (clr_flags) begin
        pass        <= 1'b0;
        id_mismatch <= 1'b0;
        ts_mismatch <= 1'b0;
        timeout     <= 1'b0;
      end
      if (cap_id) id_value <= avm_readdata;
      if (cap_ts) ts_value <= avm_readdata;
      if (do_check) begin
        id_mismatch <= (id_value != EXPECTED_ID);
        ts_mismatch <= (ts_value != EXPECTED_TS);
        pass        <= (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
      end
      if (set_timeout) timeout <= 1'b1;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_FINISH);

endmodule

// File: tb/tb_digitallock_sysid_checker.sv
// Randomized self-checking bench for digitallock_sysid_checker with a stalling Avalon slave model.
module tb_digitallock_sysid_checker;
  import digitallock_pkg::*;

  localparam int          TO     = 4;
  localparam int          MR     = 2;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1768956207;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
  logic [31:0] id_value, ts_value;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave configuration: data words and per-access stall lengths.
  logic [31:0] slv_id = EXP_ID;
  logic [31:0] slv_ts = EXP_TS;
  int          stall_id = 0;
  int          stall_ts = 0;
  int          stall_cnt;

  // Reference model memory of the last captured words.
  logic [31:0] exp_id_val = 32'd0;
  logic [31:0] exp_ts_val = 32'd0;

  // Monitor statistics.
  logic prev_read, prev_wait, prev_addr;
  int   read_rises  = 0;
  int   done_pulses = 0;
  int   stab_err    = 0;

  always #5 clock = ~clock;

  digitallock_sysid_checker #(
    .EXPECTED_ID    (EXP_ID),
    .EXPECTED_TS    (EXP_TS),
    .TIMEOUT_CYCLES (TO),
    .MAX_RETRY      (MR),
    .AUTO_START     (1'b1)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .id_mismatch     (id_mismatch),
    .ts_mismatch     (ts_mismatch),
    .timeout         (timeout),
    .id_value        (id_value),
    .ts_value        (ts_value)
  );

  assign avm_readdata    = avm_address ? slv_ts : slv_id;
  assign avm_waitrequest = avm_read && (stall_cnt < (avm_address ? stall_ts : stall_id));

  always @(posedge clock or posedge reset) begin
    if (reset) stall_cnt <= 0;
    else if (!avm_read || !avm_waitrequest) stall_cnt <= 0;
    else stall_cnt <= stall_cnt + 1;
  end

  always @(negedge clock) begin
    if (reset) begin
      prev_read <= 1'b0;
      prev_wait <= 1'b0;
      prev_addr <= 1'b0;
    end else begin
      if (prev_read && prev_wait && avm_read && (avm_address !== prev_addr))
        stab_err <= stab_err + 1;
      if (avm_read && !prev_read) read_rises <= read_rises + 1;
      if (done) done_pulses <= done_pulses + 1;
      prev_read <= avm_read;
      prev_wait <= avm_waitrequest;
      prev_addr <= avm_address;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One full check: configure the slave, launch (start pulse or reset-release auto start),
  // predict outcome from the retry/timeout rules and compare.
  task automatic run_check(input logic [31:0] idw, input logic [31:0] tsw,
                           input int sid, input int sts, input int extra,
                           input bit use_start, input string tag);
    int exp_cyc, exp_att, got_cyc, r0, p0, s0;
    bit ok;
    logic [3:0] exp_flags;
    slv_id   = idw;
    slv_ts   = tsw;
    stall_id = sid;
    stall_ts = sts;
    if (use_start) begin
      check_val({tag, "_idle"}, busy, 1'b0);
      @(negedge clock);
      start = 1'b1;
    end
    @(posedge clock);
    #1;
    start = 1'b0;
    r0 = read_rises;
    p0 = done_pulses;
    s0 = stab_err;

    exp_cyc = 1;
    exp_att = 0;
    ok      = 1'b0;
    for (int a = 0; a <= MR && !ok; a++) begin
      exp_att++;
      if (sid >= TO) begin
        exp_cyc += TO + 1;
      end else begin
        exp_cyc   += sid + 1;
        exp_id_val = idw;
        if (sts >= TO) begin
          exp_cyc += TO + 1;
        end else begin
          exp_cyc   += sts + 1;
          exp_ts_val = tsw;
          ok         = 1'b1;
        end
      end
    end
    if (ok) begin
      exp_cyc  += 1;
      exp_flags = {(idw == EXP_ID) && (tsw == EXP_TS), idw != EXP_ID, tsw != EXP_TS, 1'b0};
    end else begin
      exp_flags = 4'b0001;
    end

    got_cyc = -1;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clock);
      start = (n == extra);
      if (n == 1) begin
        check_val({tag, "_busy"}, busy, 1'b1);
        check_val({tag, "_entry_clr"}, {pass, id_mismatch, ts_mismatch, timeout}, 4'b0000);
      end
      if (done) begin
        got_cyc = n;
        break;
      end
    end
    check_val({tag, "_done_cycle"}, got_cyc, exp_cyc);
    check_val({tag, "_flags"}, {pass, id_mismatch, ts_mismatch, timeout}, exp_flags);
    check_val({tag, "_id_value"}, id_value, exp_id_val);
    check_val({tag, "_ts_value"}, ts_value, exp_ts_val);
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k == 0) check_val({tag, "_busy_after"}, busy, 1'b0);
    end
    @(posedge clock);
    #1;
    check_val({tag, "_attempts"}, read_rises - r0, exp_att);
    check_val({tag, "_done_pulses"}, done_pulses - p0, 1);
    check_val({tag, "_addr_stable"}, stab_err - s0, 0);
  endtask

  initial begin
    logic [31:0] idw, tsw;
    int sid, sts, extra;

    repeat (3) @(posedge clock);
    #1;
    check_val("rst_ctrl", {avm_read, avm_address, busy, done}, 4'b0000);
    check_val("rst_flags", {pass, id_mismatch, ts_mismatch, timeout}, 4'b0000);
    check_val("rst_id_value", id_value, 32'd0);
    check_val("rst_ts_value", ts_value, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_check(EXP_ID, EXP_TS, 0, 0, -1, 1'b0, "auto_pass");
    run_check(32'h0000_0001, EXP_TS, 0, 0, -1, 1'b1, "id_bad");
    run_check(EXP_ID, EXP_TS, 3, 3, -1, 1'b1, "stall3");
    run_check(EXP_ID, EXP_TS, 30, 30, -1, 1'b1, "stuck");
    run_check(EXP_ID, EXP_TS, 0, 2, 2, 1'b1, "start_busy");
    run_check(EXP_ID, 32'h1234_5678, 0, 0, 4, 1'b1, "start_at_done");
    run_check(EXP_ID, EXP_TS, 0, 0, -1, 1'b1, "rerun");

    // Reset in the middle of a stalled timestamp read.
    stall_id = 0;
    stall_ts = 30;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    check_val("pre_rst_rd_ts", {avm_read, avm_address}, 2'b11);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_ctrl", {avm_read, busy, done}, 3'b000);
    check_val("midrst_flags", {pass, id_mismatch, ts_mismatch, timeout}, 4'b0000);
    check_val("midrst_id_value", id_value, 32'd0);
    exp_id_val = 32'd0;
    exp_ts_val = 32'd0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    run_check(EXP_ID, EXP_TS, 0, 0, -1, 1'b0, "auto_after_rst");

    for (int i = 0; i < 20; i++) begin
      idw   = ($urandom_range(0, 1) != 0) ? EXP_ID : $urandom;
      tsw   = ($urandom_range(0, 1) != 0) ? EXP_TS : $urandom;
      sid   = $urandom_range(0, 5);
      sts   = $urandom_range(0, 5);
      extra = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 8)) : -1;
      run_check(idw, tsw, sid, sts, extra, 1'b1, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
